// File: rtl/p2_vram_arb.sv
// rtl/p2_vram_arb.sv - single-port framebuffer RAM arbiter: CPU bus port vs display scanout fetch
// Optional build macro VRAM_ARB_STATS_EN adds the stall_cnt/stall_clr CPU stall statistics.
module p2_vram_arb #(
  parameter int AW           = 17,
  parameter int DW           = 16,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_sel,
  input  logic          cpu_go_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_wel_n,
  input  logic          cpu_weu_n,
  input  logic [DW-1:0] cpu_datai,
  output logic [DW-1:0] cpu_datao,
  output logic          cpu_wait_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_data,
`ifdef VRAM_ARB_STATS_EN
  input  logic          stall_clr,
  output logic [15:0]   stall_cnt,
`endif
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr_lo,
  output logic          ram_wr_hi,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int RW = (MAX_DISP_RUN < 1) ? 1 : $clog2(MAX_DISP_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DISP_RUN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ACC   = 3'd1,
    CPU_DONE  = 3'd2,
    DISP_ACC  = 3'd3,
    DISP_DATA = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] run_cnt;
  logic [AW-1:0] cpu_addr_q;
  logic [AW-1:0] disp_addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] datao_q;
  logic          wr_lo_q;
  logic          wr_hi_q;
  logic          done_first_q;
  logic          cpu_pend;
  logic          disp_win;
  logic          cpu_grant;
  logic          disp_grant;
  logic          rd_first;

  assign cpu_pend = cpu_sel & ~cpu_go_n;
  // Display keeps priority until it has taken RUN_MAX grants in a row against a waiting CPU.
  assign disp_win = disp_req & (~cpu_pend | (run_cnt < RUN_MAX));

  always_comb begin
    state_d    = state_q;
    cpu_grant  = 1'b0;
    disp_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (disp_win) begin
          state_d    = DISP_ACC;
          disp_grant = 1'b1;
        end else if (cpu_pend) begin
          state_d   = CPU_ACC;
          cpu_grant = 1'b1;
        end
      end
      CPU_ACC:   state_d = CPU_DONE;
      CPU_DONE:  if (cpu_go_n) state_d = IDLE;
      DISP_ACC:  state_d = DISP_DATA;
      DISP_DATA: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Read data arrives during the first CPU_DONE cycle; pass it through then and hold it afterwards.
  assign rd_first = (state_q == CPU_DONE) & done_first_q & ~wr_lo_q & ~wr_hi_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      run_cnt      <= '0;
      cpu_addr_q   <= '0;
      disp_addr_q  <= '0;
      wdata_q      <= '0;
      datao_q      <= '0;
      wr_lo_q      <= 1'b0;
      wr_hi_q      <= 1'b0;
      done_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_first_q <= (state_q == CPU_ACC);
      if (cpu_grant) begin
        cpu_addr_q <= cpu_addr;
        wdata_q    <= cpu_datai;
        wr_lo_q    <= ~cpu_wel_n;
        wr_hi_q    <= ~cpu_weu_n;
      end
      if (disp_grant) disp_addr_q <= disp_addr;
      if (!cpu_pend || cpu_grant) run_cnt <= '0;
      else if (disp_grant && (run_cnt < RUN_MAX)) run_cnt <= run_cnt + 1'b1;
      if (rd_first) datao_q <= ram_rdata;
    end
  end

  // RAM strobes are gated by reset so an access interrupted by reset never writes.
  assign ram_en    = reset_n & ((state_q == CPU_ACC) | (state_q == DISP_ACC));
  assign ram_addr  = (state_q == CPU_ACC) ? cpu_addr_q : disp_addr_q;
  assign ram_wr_lo = reset_n & (state_q == CPU_ACC) & wr_lo_q;
  assign ram_wr_hi = reset_n & (state_q == CPU_ACC) & wr_hi_q;
  assign ram_wdata = wdata_q;

  assign disp_ack   = (state_q == DISP_DATA);
  assign disp_data  = (state_q == DISP_DATA) ? ram_rdata : '0;
  assign cpu_datao  = rd_first ? ram_rdata : datao_q;
  assign cpu_wait_n = ~(reset_n & cpu_pend & (state_q != CPU_DONE));

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n || stall_clr) stall_cnt <= '0;
    else if (!cpu_wait_n && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_p2_vram_arb.sv
// tb/tb_p2_vram_arb.sv - self-checking bench for p2_vram_arb (two instances: run cap 4 and 0)
module tb_p2_vram_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_sel = 1'b0, cpu_go_n = 1'b1, cpu_wel_n = 1'b1, cpu_weu_n = 1'b1;
  logic [16:0] cpu_addr = '0, disp_addr = 17'h08000;
  logic [15:0] cpu_datai = '0, cpu_datao, disp_data, ram_wdata, ram_rdata = '0;
  logic        cpu_wait_n, disp_req = 1'b0, disp_ack, ram_en, ram_wr_lo, ram_wr_hi;
  logic [16:0] ram_addr;
  logic        stall_clr = 1'b0;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_cnt, sp_stall_cnt;
`endif

  logic        sp_sel = 1'b0, sp_go_n = 1'b1, sp_req = 1'b0;
  logic [15:0] sp_datao, sp_ddata, sp_wdata, sp_rdata = '0;
  logic        sp_wait_n, sp_ack, sp_ram_en, sp_wr_lo, sp_wr_hi;
  logic [16:0] sp_ram_addr;

  int n_tests = 0, n_fail = 0;
  int ack_cnt = 0, sp_ack_cnt = 0, stall_seen = 0, wr_cnt = 0, both_cnt = 0;
  logic disp_want = 1'b0;
  logic [15:0] ref_mem [int];

  always #5 clk = ~clk;

  p2_vram_arb #(.AW(17), .DW(16), .MAX_DISP_RUN(4)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_sel(cpu_sel), .cpu_go_n(cpu_go_n), .cpu_addr(cpu_addr),
    .cpu_wel_n(cpu_wel_n), .cpu_weu_n(cpu_weu_n), .cpu_datai(cpu_datai), .cpu_datao(cpu_datao),
    .cpu_wait_n(cpu_wait_n), .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_data(disp_data),
`ifdef VRAM_ARB_STATS_EN
    .stall_clr(stall_clr), .stall_cnt(stall_cnt),
`endif
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wr_lo(ram_wr_lo), .ram_wr_hi(ram_wr_hi),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  p2_vram_arb #(.AW(17), .DW(16), .MAX_DISP_RUN(0)) dut_sp (
    .clk(clk), .reset_n(reset_n), .cpu_sel(sp_sel), .cpu_go_n(sp_go_n), .cpu_addr(17'h00040),
    .cpu_wel_n(1'b1), .cpu_weu_n(1'b1), .cpu_datai(16'h0000), .cpu_datao(sp_datao),
    .cpu_wait_n(sp_wait_n), .disp_req(sp_req), .disp_addr(17'h00080), .disp_ack(sp_ack),
    .disp_data(sp_ddata),
`ifdef VRAM_ARB_STATS_EN
    .stall_clr(stall_clr), .stall_cnt(sp_stall_cnt),
`endif
    .ram_en(sp_ram_en), .ram_addr(sp_ram_addr), .ram_wr_lo(sp_wr_lo), .ram_wr_hi(sp_wr_hi),
    .ram_wdata(sp_wdata), .ram_rdata(sp_rdata));

  // Framebuffer contents before any write: a fixed address-derived pattern.
  function automatic logic [15:0] pat(input logic [16:0] a);
    return {a[7:0], a[15:8]} ^ {a[16], 15'h2A5A};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  logic [15:0] mem [0:131071];
  bit          written [0:131071];
  logic [15:0] wmask;
  assign wmask = {{8{ram_wr_hi}}, {8{ram_wr_lo}}};

  function automatic logic [15:0] ram_peek(input logic [16:0] a);
    return written[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_peek(ram_addr);
      if (ram_wr_lo | ram_wr_hi) begin
        mem[ram_addr]     <= (ram_peek(ram_addr) & ~wmask) | (ram_wdata & wmask);
        written[ram_addr] <= 1'b1;
      end
    end
    if (sp_ram_en) sp_rdata <= sp_ram_addr[15:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observer and display requester: acks checked against the model, new address after each ack.
  initial forever begin
    @(negedge clk);
    if (!cpu_wait_n) stall_seen++;
    if (ram_en && (ram_wr_lo || ram_wr_hi)) wr_cnt++;
    if (ram_en && ram_wr_lo && ram_wr_hi) both_cnt++;
    if (sp_ack) sp_ack_cnt++;
    if (disp_ack) begin
      ack_cnt++;
      chk("disp_data", 32'(disp_data), 32'(ref_rd(disp_addr)));
      disp_addr = 17'h08000 + 17'($urandom_range(0, 255));
      if (!disp_want) disp_req = 1'b0;
    end else if (disp_want && !disp_req) begin
      disp_req = 1'b1;
    end
  end

  task automatic cpu_acc(input logic [16:0] a, input logic [15:0] d, input logic wl, input logic wu,
                         input bit raise_disp, output logic [15:0] rd, output int cyc);
    @(posedge clk); #1;
    cpu_sel = 1'b1; cpu_go_n = 1'b0; cpu_addr = a; cpu_datai = d; cpu_wel_n = wl; cpu_weu_n = wu;
    if (raise_disp) begin disp_want = 1'b1; disp_req = 1'b1; end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cpu_wait_n && cyc < 200);
    rd = cpu_datao;
    @(posedge clk); #1;
    cpu_go_n = 1'b1; cpu_sel = 1'b0;
    if (!wl || !wu)
      ref_mem[int'(a)] = {wu ? ref_rd(a)[15:8] : d[15:8], wl ? ref_rd(a)[7:0] : d[7:0]};
  endtask

  task automatic sp_acc(input bit raise, input int gap, output int cyc);
    @(posedge clk); #1;
    sp_sel = 1'b1; sp_go_n = 1'b0;
    if (raise) sp_req = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!sp_wait_n && cyc < 200);
    @(posedge clk); #1;
    sp_go_n = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic disp_quiesce();
    disp_want = 1'b0;
    for (int i = 0; i < 40 && disp_req; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int cyc, a0, w0, b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_datao", 32'(cpu_datao), 32'd0);
    chk("rst_disp_ack", 32'(disp_ack), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);

    // 1: lone full-word write
    w0 = wr_cnt; b0 = both_cnt;
    cpu_acc(17'h00010, 16'hA5C3, 1'b0, 1'b0, 1'b0, rd, cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_wr_cycles", 32'(wr_cnt - w0), 32'd1);
    chk("t1_both_bytes", 32'(both_cnt - b0), 32'd1);

    // 2: upper-byte write then read back
    w0 = wr_cnt; b0 = both_cnt;
    cpu_acc(17'h00010, 16'h1234, 1'b1, 1'b0, 1'b0, rd, cyc);
    chk("t2_wr_cycles", 32'(wr_cnt - w0), 32'd1);
    chk("t2_both_bytes", 32'(both_cnt - b0), 32'd0);
    cpu_acc(17'h00010, 16'h0000, 1'b1, 1'b1, 1'b0, rd, cyc);
    chk("t2_readback", 32'(rd), 32'h12C3);
    chk("t2_ref", 32'(rd), 32'(ref_rd(17'h00010)));

    // 3: simultaneous display and CPU read: four display grants, then the CPU
    a0 = ack_cnt;
    cpu_acc(17'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, rd, cyc);
    chk("t3_acks_before_cpu", 32'(ack_cnt - a0), 32'd4);
    chk("t3_latency", 32'(cyc), 32'd15);
    chk("t3_data", 32'(rd), 32'h12C3);
    a0 = ack_cnt;
    repeat (10) @(posedge clk);
    chk("t3_disp_resumes", 32'(ack_cnt - a0 >= 2), 32'd1);
`ifdef VRAM_ARB_STATS_EN
    #1 chk("t6_stall_cnt", 32'(stall_cnt), 32'(stall_seen));
`endif
    disp_quiesce();
    a0 = ack_cnt;
    cpu_acc(17'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, rd, cyc);
    chk("t3_run_cleared_acks", 32'(ack_cnt - a0), 32'd4);
    chk("t3_run_cleared_lat", 32'(cyc), 32'd15);
    disp_quiesce();

`ifdef VRAM_ARB_STATS_EN
    #1 chk("t6_stall_cnt2", 32'(stall_cnt), 32'(stall_seen));
    @(posedge clk); #1 stall_clr = 1'b1;
    @(posedge clk); #1 stall_clr = 1'b0;
    chk("t6_clear", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1 force dut.stall_cnt = 16'hFFF8;
    #1 release dut.stall_cnt;
    cpu_acc(17'h00010, 16'h0000, 1'b1, 1'b1, 1'b1, rd, cyc);
    disp_quiesce();
    #1 chk("t6_saturate", 32'(stall_cnt), 32'h0000FFFF);
`endif

    // 4: CPU strict priority instance
    a0 = sp_ack_cnt;
    for (int i = 0; i < 8; i++) begin
      sp_acc(i == 0, (i < 4) ? 0 : 1, cyc);
      chk($sformatf("t4_lat_%0d", i), 32'(cyc), (i <= 4) ? 32'd3 : 32'd5);
      if (i == 4) chk("t4_no_disp_before_gap", 32'(sp_ack_cnt - a0), 32'd0);
    end
    chk("t4_disp_in_gaps", 32'(sp_ack_cnt - a0), 32'd3);

    // 5: reset in the middle of a write to the last word
    cpu_acc(17'h1FFFF, 16'h0F0F, 1'b0, 1'b0, 1'b0, rd, cyc);
    @(posedge clk); #1;
    cpu_sel = 1'b1; cpu_go_n = 1'b0; cpu_addr = 17'h1FFFF; cpu_datai = 16'hBEEF;
    cpu_wel_n = 1'b0; cpu_weu_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; cpu_go_n = 1'b1; cpu_sel = 1'b0;
    @(negedge clk);
    chk("t5_ram_en", 32'(ram_en), 32'd0);
    chk("t5_wr_lo", 32'(ram_wr_lo), 32'd0);
    chk("t5_wr_hi", 32'(ram_wr_hi), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_ram_en", 32'(ram_en), 32'd0);
    chk("t5_wait_n", 32'(cpu_wait_n), 32'd1);
    chk("t5_word_kept", 32'(ram_peek(17'h1FFFF)), 32'h0F0F);
    cpu_acc(17'h1FFFF, 16'h0000, 1'b1, 1'b1, 1'b0, rd, cyc);
    chk("t5_readback", 32'(rd), 32'h0F0F);
    chk("t5_idle_latency", 32'(cyc), 32'd3);

    // Randomized traffic against the memory model, display on and off
    for (int i = 0; i < 30; i++) begin
      logic [16:0] a;
      logic [15:0] d;
      logic wl, wu;
      a = 17'($urandom_range(0, 255));
      d = 16'($urandom);
      wl = 1'($urandom); wu = 1'($urandom);
      disp_want = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      w0 = wr_cnt;
      cpu_acc(a, d, wl, wu, 1'b0, rd, cyc);
      chk($sformatf("rnd_lat_%0d", i), 32'(cyc >= 3 && cyc <= 17), 32'd1);
      if (wl && wu) chk($sformatf("rnd_rd_%0d", i), 32'(rd), 32'(ref_rd(a)));
      else chk($sformatf("rnd_wr_%0d", i), 32'(wr_cnt - w0), 32'd1);
    end
    disp_quiesce();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
